// File: rtl/mux_nto1_arb.sv
// N-to-1 arbitrating mux with a one-entry registered output stage (round-robin or fixed select).
// Optional even-parity output is enabled by defining MUX_NTO1_ARB_PARITY_EN.
module mux_nto1_arb #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] InData,
  input  logic [CHANNELS-1:0]       InValid,
  output logic [CHANNELS-1:0]       InReady,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Select,
  output logic [WIDTH-1:0]          OutData,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [SEL_W-1:0]          OutChannel
`ifdef MUX_NTO1_ARB_PARITY_EN
  ,
  output logic                      OutParity
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_p1, state_d;
  logic [WIDTH-1:0]  data_p1, data_d;
  logic [SEL_W-1:0]  chan_p1, chan_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              load_en;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  gnt_data;
  int                idx;

`ifdef MUX_NTO1_ARB_PARITY_EN
  logic par_p1, par_d;

  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  // Grant decision: fixed select, or first valid channel at/after the round-robin pointer
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (Mode) begin
      if ((int'(Select) < CHANNELS) && (|(InValid & (CHANNELS'(1) << Select)))) begin
        gnt_vld = 1'b1;
        gnt_idx = Select;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        idx = (int'(ptr_q) + i) % CHANNELS;
        if (!gnt_vld && (|(InValid & (CHANNELS'(1) << idx)))) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(idx);
        end
      end
    end
    gnt_data = WIDTH'(InData >> (int'(gnt_idx) * WIDTH));
  end

  assign load_en = (state_p1 == EMPTY) || OutReady;
  assign InReady = (gnt_vld && load_en && !Reset) ? (CHANNELS'(1) << gnt_idx) : '0;

  always_comb begin
    state_d = state_p1;
    data_d  = data_p1;
    chan_d  = chan_p1;
    ptr_d   = ptr_q;
`ifdef MUX_NTO1_ARB_PARITY_EN
    par_d   = par_p1;
`endif
    if (load_en) begin
      if (gnt_vld) begin
        state_d = FULL;
        data_d  = gnt_data;
        chan_d  = gnt_idx;
`ifdef MUX_NTO1_ARB_PARITY_EN
        par_d   = even_par(gnt_data);
`endif
        if (!Mode) begin
          ptr_d = SEL_W'((int'(gnt_idx) + 1) % CHANNELS);
        end
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // Output stage register (p1)
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_p1 <= EMPTY;
      data_p1  <= '0;
      chan_p1  <= '0;
      ptr_q    <= '0;
`ifdef MUX_NTO1_ARB_PARITY_EN
      par_p1   <= 1'b0;
`endif
    end else begin
      state_p1 <= state_d;
      data_p1  <= data_d;
      chan_p1  <= chan_d;
      ptr_q    <= ptr_d;
`ifdef MUX_NTO1_ARB_PARITY_EN
      par_p1   <= par_d;
`endif
    end
  end

  assign OutData    = data_p1;
  assign OutValid   = (state_p1 == FULL);
  assign OutChannel = chan_p1;
`ifdef MUX_NTO1_ARB_PARITY_EN
  assign OutParity  = par_p1;
`endif

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Directed bench for mux_nto1_arb: a 4-channel instance plus a 3-channel instance
// for the out-of-range select case.
module tb_mux_nto1_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;

  logic [71:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_chan3;

  int nchk = 0;
  int nerr = 0;

  logic [23:0] chd [4];

`ifdef MUX_NTO1_ARB_PARITY_EN
  logic out_par, out_par3;
`endif

  always #5 clk = ~clk;

  mux_nto1_arb #(.WIDTH(24), .CHANNELS(4), .SEL_W(2)) dut (
    .Clock(clk), .Reset(rst), .InData(in_data), .InValid(in_valid), .InReady(in_ready),
    .Mode(mode), .Select(sel), .OutData(out_data), .OutValid(out_valid),
    .OutReady(out_ready), .OutChannel(out_chan)
`ifdef MUX_NTO1_ARB_PARITY_EN
    , .OutParity(out_par)
`endif
  );

  mux_nto1_arb #(.WIDTH(24), .CHANNELS(3), .SEL_W(2)) dut3 (
    .Clock(clk), .Reset(rst), .InData(in_data3), .InValid(in_valid3), .InReady(in_ready3),
    .Mode(mode3), .Select(sel3), .OutData(out_data3), .OutValid(out_valid3),
    .OutReady(out_ready3), .OutChannel(out_chan3)
`ifdef MUX_NTO1_ARB_PARITY_EN
    , .OutParity(out_par3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pack_data();
    in_data = {chd[3], chd[2], chd[1], chd[0]};
  endtask

  initial begin
    int exp_seq [6];
    exp_seq = '{0, 1, 2, 3, 0, 1};
    chd[0] = 24'h111111;
    chd[1] = 24'h222222;
    chd[2] = 24'hABCDEF;
    chd[3] = 24'h333333;
    rst = 1'b1;
    pack_data();
    in_valid = 4'hF; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    in_data3 = {24'h777777, 24'h666666, 24'h555555};
    in_valid3 = 3'b111; mode3 = 1'b1; sel3 = 2'd3; out_ready3 = 1'b1;
    cyc(); cyc();

    // Reset state and InReady gated during reset
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_chan", 64'(out_chan), 64'd0);
    chk("rst_inready", 64'(in_ready), 64'd0);

    // Fixed selection of channel 2
    rst = 1'b0; mode = 1'b1; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    settle();
    chk("fix_inready", 64'(in_ready), 64'h4);
    cyc();
    chk("fix_valid", 64'(out_valid), 64'd1);
    chk("fix_data", 64'(out_data), 64'hABCDEF);
    chk("fix_chan", 64'(out_chan), 64'd2);

    // Fixed select of a channel that is not offering: nothing granted
    sel = 2'd1;
    settle();
    chk("fix_noreq_inready", 64'(in_ready), 64'd0);

    // Round robin, all requesting; pointer untouched by the fixed-mode transfer
    mode = 1'b0; in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_chan", 64'(out_chan), 64'(exp_seq[i]));
      chk("rr_data", 64'(out_data), 64'(chd[exp_seq[i]]));
      chk("rr_valid", 64'(out_valid), 64'd1);
    end

    // Backpressure: hold ch1 word while Mode/Select wiggle
    out_ready = 1'b0;
    settle();
    chk("hold_inready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      mode = (i == 1); sel = 2'(i + 1);
      cyc();
      chk("hold_chan", 64'(out_chan), 64'd1);
      chk("hold_data", 64'(out_data), 64'h222222);
      chk("hold_valid", 64'(out_valid), 64'd1);
    end
    mode = 1'b0; out_ready = 1'b1;
    settle();
    chk("release_inready", 64'(in_ready), 64'h4);
    cyc();
    chk("release_chan", 64'(out_chan), 64'd2);
    chk("release_data", 64'(out_data), 64'hABCDEF);

    // Drain with no requests; pointer must stay at 3
    in_valid = 4'h0;
    settle();
    chk("idle_inready", 64'(in_ready), 64'd0);
    cyc();
    chk("drain_valid", 64'(out_valid), 64'd0);
    cyc();
    in_valid = 4'hF;
    settle();
    chk("ptr_kept_inready", 64'(in_ready), 64'h8);
    cyc();
    chk("ptr_kept_chan", 64'(out_chan), 64'd3);
    cyc();
    chk("wrap_chan", 64'(out_chan), 64'd0);

    // Reset while FULL with a pending transfer
    rst = 1'b1;
    settle();
    chk("rst_full_inready", 64'(in_ready), 64'd0);
    cyc();
    chk("rst_full_valid", 64'(out_valid), 64'd0);
    chk("rst_full_data", 64'(out_data), 64'd0);
    chk("rst_full_chan", 64'(out_chan), 64'd0);
    rst = 1'b0;
    settle();
    chk("post_rst_inready", 64'(in_ready), 64'h1);
    cyc();
    chk("post_rst_chan", 64'(out_chan), 64'd0);
    chk("post_rst_data", 64'(out_data), 64'h111111);

    // 3-channel instance: Select beyond channel count grants nothing
    settle();
    chk("sel3_oor_inready", 64'(in_ready3), 64'd0);
    cyc();
    chk("sel3_oor_valid", 64'(out_valid3), 64'd0);
    sel3 = 2'd2;
    settle();
    chk("sel3_ok_inready", 64'(in_ready3), 64'h4);
    cyc();
    chk("sel3_ok_data", 64'(out_data3), 64'h777777);

`ifdef MUX_NTO1_ARB_PARITY_EN
    mode = 1'b1; sel = 2'd0; in_valid = 4'b0001;
    chd[0] = 24'h000007; pack_data();
    cyc();
    chk("par_odd", 64'(out_par), 64'd1);
    chd[0] = 24'h000003; pack_data();
    cyc();
    chk("par_even", 64'(out_par), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mux_nto1_arb.md
MUX_NTO1_ARB -- requirements
Module: mux_nto1_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, data width per channel (1..64).
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of input channels (2..8).
REQ-003 The block SHALL have parameter SEL_W, default 2, select/channel-index width; 2**SEL_W >= CHANNELS is required.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 InData  input  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 InValid  input  CHANNELS  per-channel request; bit k set means InData channel k is offered.
REQ-008 InReady  output  CHANNELS  per-channel accept, one-hot or zero; InValid[k] & InReady[k] is a transfer.
REQ-009 Mode  input  1  0 = round-robin arbitration, 1 = fixed selection by Select.
REQ-010 Select  input  SEL_W  channel index used when Mode = 1.
REQ-011 OutData  output  WIDTH  registered selected data.
REQ-012 OutValid  output  1  OutData holds an untaken word.
REQ-013 OutReady  input  1  downstream accept; OutValid & OutReady is a transfer.
REQ-014 OutChannel  output  SEL_W  index of the channel that supplied OutData.

Function
REQ-015 Output stage SHALL be a one-entry register with states EMPTY (OutValid = 0) and FULL (OutValid = 1).
REQ-016 Load enable SHALL be: state EMPTY, or state FULL with OutReady = 1 (same-cycle drain and refill, full throughput).
REQ-017 InReady SHALL be zero whenever load enable is 0; InReady SHALL depend combinationally on InValid, Mode, Select, OutReady and state only.
REQ-018 Mode 1: grant channel Select when InValid[Select] = 1; Select >= CHANNELS SHALL grant nothing.
REQ-019 Mode 0: grant the first valid channel searching upward from pointer Ptr, wrapping CHANNELS-1 -> 0.
REQ-020 Ptr SHALL update to (granted index + 1) mod CHANNELS only on a transfer in Mode 0; unchanged otherwise, including Mode 1 transfers.
REQ-021 On a grant with load enable, OutData <= granted channel data, OutChannel <= granted index, state -> FULL, at the next edge (latency 1 cycle).
REQ-022 FULL with OutReady = 1 and no grant SHALL go to EMPTY; FULL with OutReady = 0 SHALL hold OutData/OutChannel stable.
REQ-023 Mode or Select changes SHALL affect only the next grant decision, never the held output word.
REQ-024 No InValid set with load enable SHALL produce no transfer and no Ptr change.

Reset
REQ-025 Reset = 1 at an edge SHALL force state EMPTY, OutValid = 0, OutData = 0, OutChannel = 0, Ptr = 0, overriding any simultaneous transfer.
REQ-026 While Reset = 1, InReady SHALL be all zero; a word held at reset assertion SHALL be discarded.

Configuration
REQ-027 Macro MUX_NTO1_ARB_PARITY_EN defined: extra output OutParity (1 bit) SHALL be registered with OutData as even parity (XOR reduction) of the loaded word; reset value 0.
REQ-028 Macro MUX_NTO1_ARB_PARITY_EN undefined: OutParity port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, then Mode=1, Select=2, InValid=4'b0100, InData ch2=24'hABCDEF, OutReady=1 -> InReady=4'b0100, next cycle OutValid=1, OutData=24'hABCDEF, OutChannel=2.
REQ-030 Mode=0, InValid=4'b1111 held, OutReady=1 for 6 cycles -> OutChannel sequence 0,1,2,3,0,1, one word per cycle.
REQ-031 Output FULL from ch1, OutReady=0 for 3 cycles with InValid=4'b1111 -> InReady=0, OutData/OutChannel stable, Ptr unchanged; OutReady=1 -> ch1 taken and ch2 loaded same edge.
REQ-032 Mode=1, Select=3 with CHANNELS=3, InValid=3'b111 -> InReady=0, OutValid stays 0.
REQ-033 Reset asserted while FULL and OutReady=1, InValid=4'b1111 -> next cycle OutValid=0, OutData=0, Ptr=0; first post-reset Mode 0 grant is ch0.
REQ-034 With MUX_NTO1_ARB_PARITY_EN, load 24'h000007 -> OutParity=1; load 24'h000003 -> OutParity=0.
